// File: rtl/button_conditioner.sv
// Five-button front end: two-flop synchronizer, per-button debounce FSM with
// optional auto-repeat, and a registered priority-encoded event output.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bC,
  input  logic       bL,
  input  logic       bU,
  input  logic       bR,
  input  logic       bD,
  output logic [4:0] pulse,
  output logic [4:0] held,
  output logic       evt_valid,
  output logic [2:0] evt_code
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [15:0] DB_N = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] RD_N = 16'(REPEAT_DELAY);
  localparam logic [15:0] RP_N = 16'(REPEAT_PERIOD);

  logic [4:0]  raw;
  logic [4:0]  sync1_q, sync2_q;
  state_t      st_q [5];
  state_t      st_d [5];
  logic [15:0] cnt_q [5];
  logic [15:0] cnt_d [5];
  logic [15:0] cnt_nx [5];
  logic [15:0] rpt_q [5];
  logic [15:0] rpt_d [5];
  logic [15:0] rpt_nx [5];
  logic [4:0]  first_q, first_d;
  logic [4:0]  pulse_q, pulse_d;
  logic [4:0]  held_q, held_d;
  logic        evt_valid_q;
  logic [2:0]  evt_code_q, evt_code_d;

  assign raw = {bD, bR, bU, bL, bC};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // cnt_nx counts the current stable cycle, so the accept edge lands
  // 2 + DEBOUNCE_CYCLES edges after the raw level first changes.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      cnt_nx[i]   = sat_inc(cnt_q[i]);
      rpt_nx[i]   = sat_inc(rpt_q[i]);
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      rpt_d[i]    = rpt_q[i];
      first_d[i]  = first_q[i];
      pulse_d[i]  = 1'b0;
      held_d[i]   = held_q[i];
      case (st_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            if (DB_N <= 16'd1) begin
              st_d[i]    = HELD;
              pulse_d[i] = 1'b1;
              held_d[i]  = 1'b1;
              rpt_d[i]   = '0;
              first_d[i] = 1'b1;
            end else begin
              st_d[i]  = PRESS_WAIT;
              cnt_d[i] = 16'd1;
            end
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_nx[i] >= DB_N) begin
            st_d[i]    = HELD;
            pulse_d[i] = 1'b1;
            held_d[i]  = 1'b1;
            rpt_d[i]   = '0;
            first_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_nx[i];
          end
        end
        HELD: begin
          held_d[i] = 1'b1;
          if (!sync2_q[i]) begin
            if (DB_N <= 16'd1) begin
              st_d[i]   = IDLE;
              held_d[i] = 1'b0;
            end else begin
              st_d[i]  = RELEASE_WAIT;
              cnt_d[i] = 16'd1;
            end
          end else if (RD_N != '0) begin
            rpt_d[i] = rpt_nx[i];
            if (first_q[i] ? (rpt_nx[i] >= RD_N) : (rpt_nx[i] >= RP_N)) begin
              pulse_d[i] = 1'b1;
              rpt_d[i]   = '0;
              first_d[i] = 1'b0;
            end
          end
        end
        RELEASE_WAIT: begin
          // repeat timer is left untouched here so HELD resumes it
          if (sync2_q[i]) begin
            st_d[i] = HELD;
          end else if (cnt_nx[i] >= DB_N) begin
            st_d[i]   = IDLE;
            held_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_nx[i];
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    evt_code_d = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (pulse_d[4 - i]) evt_code_d = 3'(4 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      first_q     <= '0;
      pulse_q     <= '0;
      held_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        rpt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      first_q     <= first_d;
      pulse_q     <= pulse_d;
      held_q      <= held_d;
      evt_valid_q <= |pulse_d;
      evt_code_q  <= evt_code_d;
      for (int unsigned i = 0; i < 5; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        rpt_q[i] <= rpt_d[i];
      end
    end
  end

  assign pulse     = pulse_q;
  assign held      = held_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, directed corner sequences and
// randomized stimulus against a run-length reference model.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bC, bL, bU, bR, bD;
  logic [4:0] pulse_a, held_a, pulse_b, held_b;
  logic       ev_a, ev_b;
  logic [2:0] code_a, code_b;

  button_conditioner dut_a (
    .clk(clk), .rst(rst), .bC(bC), .bL(bL), .bU(bU), .bR(bR), .bD(bD),
    .pulse(pulse_a), .held(held_a), .evt_valid(ev_a), .evt_code(code_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(8), .REPEAT_DELAY(50), .REPEAT_PERIOD(20)) dut_b (
    .clk(clk), .rst(rst), .bC(bC), .bL(bL), .bU(bU), .bR(bR), .bD(bD),
    .pulse(pulse_b), .held(held_b), .evt_valid(ev_b), .evt_code(code_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        chk_en   = 1'b0;
  int unsigned pc [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic set_btn(input logic [4:0] v);
    {bD, bR, bU, bL, bC} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) if (pulse_a[i]) pc[i]++;
  endtask

  task automatic clr_pc();
    for (int i = 0; i < 5; i++) pc[i] = 0;
  endtask

  task automatic do_reset();
    set_btn(5'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model: s is raw delayed two edges; a level is accepted once s
  // differs from it for DEBOUNCE consecutive edges; repeats fall at
  // DELAY + k*PERIOD edges of uninterrupted-held time after acceptance.
  localparam int unsigned DB = 8;
  int unsigned rd [2] = '{0, 50};
  int unsigned rp [2] = '{16, 20};
  logic [4:0]  mh1 [2];
  logic [4:0]  mh2 [2];
  logic [4:0]  lvl [2];
  logic [4:0]  ep  [2];
  int unsigned run [2][5];
  int unsigned tmr [2][5];

  task automatic model_step(input int m, input logic [4:0] r, input logic rs);
    logic [4:0] s;
    if (rs) begin
      mh1[m] = '0; mh2[m] = '0; lvl[m] = '0; ep[m] = '0;
      for (int i = 0; i < 5; i++) begin run[m][i] = 0; tmr[m][i] = 0; end
    end else begin
      s = mh2[m];
      ep[m] = '0;
      for (int i = 0; i < 5; i++) begin
        if (lvl[m][i] && run[m][i] == 0 && s[i]) begin
          tmr[m][i]++;
          if (rd[m] != 0 && (tmr[m][i] == rd[m] ||
              (tmr[m][i] > rd[m] && (tmr[m][i] - rd[m]) % rp[m] == 0)))
            ep[m][i] = 1'b1;
        end
        if (s[i] == lvl[m][i]) run[m][i] = 0;
        else begin
          run[m][i]++;
          if (run[m][i] == DB) begin
            lvl[m][i] = s[i];
            run[m][i] = 0;
            if (s[i]) begin ep[m][i] = 1'b1; tmr[m][i] = 0; end
          end
        end
      end
      mh2[m] = mh1[m];
      mh1[m] = r;
    end
  endtask

  function automatic logic [2:0] ecode(input logic [4:0] p);
    logic [2:0] c = '0;
    for (int i = 4; i >= 0; i--) if (p[i]) c = 3'(i);
    return c;
  endfunction

  always @(posedge clk) begin
    model_step(0, {bD, bR, bU, bL, bC}, rst);
    model_step(1, {bD, bR, bU, bL, bC}, rst);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ref_a", {pulse_a, held_a, ev_a, code_a}, {ep[0], lvl[0], |ep[0], ecode(ep[0])});
      chk("ref_b", {pulse_b, held_b, ev_b, code_b}, {ep[1], lvl[1], |ep[1], ecode(ep[1])});
    end
  end

  typedef struct {
    string       name;
    logic [4:0]  btn;
    int unsigned on_c;
    int unsigned off_c;
    logic [4:0]  exp_once;
  } vec_t;

  vec_t tbl [7];
  int unsigned rep_q [$];
  int unsigned exp_rep [6] = '{10, 60, 80, 100, 120, 140};

  initial begin
    logic [4:0]  seq_m [6] = '{5'b10000, 5'b00100, 5'b01000, 5'b00010, 5'b10000, 5'b00100};
    int unsigned seq_n [6] = '{1, 2, 5, 5, 10, 10};
    int unsigned exp_pc [5] = '{0, 5, 12, 5, 11};
    int unsigned found;
    logic        seen;

    tbl[0] = '{"U_press",   5'b00100, 40, 40, 5'b00100};
    tbl[1] = '{"R_glitch5", 5'b01000,  5, 20, 5'b00000};
    tbl[2] = '{"L_stable8", 5'b00010,  8, 20, 5'b00010};
    tbl[3] = '{"L_stable7", 5'b00010,  7, 20, 5'b00000};
    tbl[4] = '{"CD_same",   5'b10001, 40, 40, 5'b10001};
    tbl[5] = '{"all_five",  5'b11111, 30, 30, 5'b11111};
    tbl[6] = '{"C_short1",  5'b00001,  1, 20, 5'b00000};

    rst = 1'b1;
    set_btn(5'b0);
    clr_pc();
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_outputs", {pulse_a, held_a, ev_a, code_a}, 32'd0);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      clr_pc();
      set_btn(tbl[t].btn);
      for (int k = 0; k < int'(tbl[t].on_c); k++) tick();
      set_btn(5'b0);
      for (int k = 0; k < int'(tbl[t].off_c); k++) tick();
      for (int i = 0; i < 5; i++)
        chk($sformatf("%s_cnt%0d", tbl[t].name, i), pc[i], {31'd0, tbl[t].exp_once[i]});
      chk({tbl[t].name, "_held_end"}, held_a, 32'd0);
    end

    // Exact press latency, event code and release timing on U
    do_reset();
    clr_pc();
    set_btn(5'b00100);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 9)  chk("u_pulse_e9", pulse_a, 32'd0);
      if (k == 10) begin
        chk("u_pulse_e10", pulse_a, 32'b00100);
        chk("u_code_e10", code_a, 32'd2);
        chk("u_valid_e10", ev_a, 32'd1);
      end
      if (k == 11) begin
        chk("u_pulse_e11", pulse_a, 32'd0);
        chk("u_held_e11", held_a, 32'b00100);
      end
    end
    set_btn(5'b0);
    for (int k = 41; k <= 60; k++) begin
      tick();
      if (k == 49) chk("u_held_e49", held_a[2], 32'd1);
      if (k == 50) chk("u_held_e50", held_a[2], 32'd0);
    end
    chk("u_pulse_count", pc[2], 32'd1);

    // R bounce: 5 on, 3 off, 5 on, off
    do_reset();
    clr_pc();
    seen = 1'b0;
    for (int k = 0; k < 33; k++) begin
      set_btn((k < 5 || (k >= 8 && k < 13)) ? 5'b01000 : 5'b00000);
      tick();
      if (held_a[3]) seen = 1'b1;
    end
    chk("r_bounce_pulses", pc[3], 32'd0);
    chk("r_bounce_held", seen, 32'd0);

    // Auto-repeat on dut_b: L held 150 cycles
    do_reset();
    rep_q.delete();
    set_btn(5'b00010);
    for (int unsigned k = 1; k <= 200; k++) begin
      tick();
      if (pulse_b[1]) rep_q.push_back(k);
      if (k == 150) set_btn(5'b0);
    end
    chk("rep_count", rep_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rep_edge%0d", i), (i < rep_q.size()) ? rep_q[i] : 32'hFFFF, exp_rep[i]);

    // C and D rising together
    do_reset();
    set_btn(5'b10001);
    found = 0;
    for (int unsigned k = 1; k <= 30 && found == 0; k++) begin
      tick();
      if (pulse_a != 5'b0) found = k;
    end
    chk("cd_latency", found, 32'd10);
    chk("cd_pulse", pulse_a, 32'b10001);
    chk("cd_valid", ev_a, 32'd1);
    chk("cd_code", code_a, 32'd0);
    tick();
    chk("cd_pulse_next", pulse_a, 32'd0);
    set_btn(5'b0);
    for (int k = 0; k < 20; k++) tick();

    // Reset while D is held, then fresh acceptance
    do_reset();
    set_btn(5'b10000);
    for (int k = 0; k < 20; k++) tick();
    chk("d_held_before_rst", held_a, 32'b10000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d_after_rst", {pulse_a, held_a, ev_a, code_a}, 32'd0);
    found = 0;
    for (int unsigned k = 1; k <= 30 && found == 0; k++) begin
      tick();
      if (pulse_a[4]) found = k;
    end
    chk("d_relatency", found, 32'd10);
    set_btn(5'b0);
    for (int k = 0; k < 20; k++) tick();

    // Press sequence 1D 2U 5R 5L 10D 10U
    do_reset();
    clr_pc();
    for (int j = 0; j < 6; j++)
      for (int n = 0; n < int'(seq_n[j]); n++) begin
        set_btn(seq_m[j]);
        for (int k = 0; k < 40; k++) tick();
        set_btn(5'b0);
        for (int k = 0; k < 40; k++) tick();
      end
    for (int i = 0; i < 5; i++) chk($sformatf("seq_cnt%0d", i), pc[i], exp_pc[i]);

    // Randomized segments; the reference model checks every cycle
    for (int n = 0; n < 300; n++) begin
      int unsigned dur;
      set_btn(5'($urandom_range(0, 31)));
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(1, 120);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      for (int k = 0; k < int'(dur); k++) tick();
    end
    set_btn(5'b0);
    for (int k = 0; k < 20; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
